// File: rtl/mips_pc.sv
// rtl/mips_pc.sv - IF-stage program counter with step/stall gating and PC+4/PC+8 adders
module mips_pc #(
    parameter int                      SIZE_ADDR_PC = 32,
    parameter logic [SIZE_ADDR_PC-1:0] PC_RESET_VAL = '0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic                    i_pc_write,
    input  logic [SIZE_ADDR_PC-1:0] i_NPC,
    output logic [SIZE_ADDR_PC-1:0] o_pc,
    output logic [SIZE_ADDR_PC-1:0] o_pc_4,
    output logic [SIZE_ADDR_PC-1:0] o_pc_8
);

    logic [SIZE_ADDR_PC-1:0] pc_q;
    logic                    pc_load;

    // Equality against 1 means an unknown enable never qualifies as a load.
    assign pc_load = (i_step == 1'b1) && (i_pc_write == 1'b1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q <= PC_RESET_VAL;
        end else if (pc_load) begin
            pc_q <= i_NPC;
        end
    end

    assign o_pc   = pc_q;
    assign o_pc_4 = pc_q + SIZE_ADDR_PC'(4);
    assign o_pc_8 = pc_q + SIZE_ADDR_PC'(8);

endmodule

// File: tb/tb_mips_pc.sv
// tb/tb_mips_pc.sv - self-checking bench for mips_pc: reference model plus directed literals
module tb_mips_pc;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic        pc_write;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] pc_8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_pc;
    bit          model_valid = 1'b0;

    mips_pc #(
        .SIZE_ADDR_PC(32),
        .PC_RESET_VAL(32'h0)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_step     (step),
        .i_pc_write (pc_write),
        .i_NPC      (npc),
        .o_pc       (pc),
        .o_pc_4     (pc_4),
        .o_pc_8     (pc_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_known(input string name, input logic [31:0] act);
        total_cnt++;
        if (!$isunknown(act)) pass_cnt++;
        else $display("FAIL %s: got %h expected a known value", name, act);
    endtask

    // Reference: the PC is whatever was last accepted, reset wins, arithmetic wraps at 2^32.
    always @(posedge clk or negedge rst_n) begin
        if (rst_n !== 1'b1) begin
            exp_pc      = 32'h0;
            model_valid = 1'b1;
        end else if (step === 1'b1 && pc_write === 1'b1) begin
            exp_pc = npc;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_pc",   pc,   exp_pc);
            check("model_pc_4", pc_4, exp_pc + 32'd4);
            check("model_pc_8", pc_8, exp_pc + 32'd8);
            check_known("pc_known", pc);
        end
    end

    task automatic drive(input logic s, input logic w, input logic [31:0] n);
        @(negedge clk);
        #1;
        step     = s;
        pc_write = w;
        npc      = n;
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_trio(input string name, input logic [31:0] e_pc,
                              input logic [31:0] e_4, input logic [31:0] e_8);
        check({name, "_pc"},   pc,   e_pc);
        check({name, "_pc_4"}, pc_4, e_4);
        check({name, "_pc_8"}, pc_8, e_8);
    endtask

    typedef struct {
        logic        s;
        logic        w;
        logic [31:0] n;
    } vec_t;

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b1, 1'b1, 32'h0000_1234};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0003};
        vecs[3] = '{1'b1, 1'b0, 32'h0BAD_0BAD};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0010};

        rst_n    = 1'b1;
        step     = 1'b1;
        pc_write = 1'b1;
        npc      = 32'hDEAD_BEEF;

        #1 rst_n = 1'b0;
        #2;
        check_trio("reset_no_edge", 32'h0, 32'h4, 32'h8);

        repeat (2) edge_then_settle();
        check_trio("reset_held", 32'h0, 32'h4, 32'h8);

        drive(1'b0, 1'b0, 32'h1);
        rst_n = 1'b1;
        edge_then_settle();
        check("release_no_load", pc, 32'h0);

        drive(1'b1, 1'b1, 32'h1);
        edge_then_settle();
        check_trio("load_1", 32'h1, 32'h5, 32'h9);

        drive(1'b1, 1'b1, 32'h40);
        edge_then_settle();
        check_trio("load_40", 32'h40, 32'h44, 32'h48);

        drive(1'b1, 1'b0, 32'h100);
        repeat (3) edge_then_settle();
        check("stall_hold", pc, 32'h40);

        drive(1'b0, 1'b1, 32'h100);
        repeat (3) edge_then_settle();
        check("halt_hold", pc, 32'h40);

        drive(1'b1, 1'b1, 32'h100);
        edge_then_settle();
        check("resume_load", pc, 32'h100);

        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        edge_then_settle();
        check_trio("wrap_fc", 32'hFFFF_FFFC, 32'h0, 32'h4);

        drive(1'b1, 1'b1, 32'hFFFF_FFF8);
        edge_then_settle();
        check_trio("wrap_f8", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].w, vecs[i].n);
            edge_then_settle();
        end
        check("table_end", pc, 32'h10);

        drive(1'b1, 1'b1, 32'h100);
        edge_then_settle();
        check("pre_async", pc, 32'h100);

        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_trio("async_mid", 32'h0, 32'h4, 32'h8);

        npc = 32'h200;
        edge_then_settle();
        check("reset_over_load", pc, 32'h0);

        drive(1'b1, 1'b1, 32'h200);
        edge_then_settle();
        check("reset_over_load2", pc, 32'h0);

        drive(1'bx, 1'bx, 32'hx);
        rst_n = 1'b1;
        repeat (4) edge_then_settle();
        check_known("x_enables", pc);

        drive(1'b1, 1'b1, 32'h3C);
        edge_then_settle();
        check_trio("after_x", 32'h3C, 32'h40, 32'h44);

        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
